// File: rtl/riscv_prog_loader_pkg.sv
// riscv_prog_loader_pkg: loader FSM state encodings and the default frame start byte.
package riscv_prog_loader_pkg;
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK} state_t;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/riscv_prog_loader.sv
// riscv_prog_loader: framed byte-stream loader that writes 32-bit words into instruction memory
// and holds the core in reset until a frame with a good XOR checksum has been loaded.
module riscv_prog_loader
   import riscv_prog_loader_pkg::*;
#(
   parameter int         ADDR_W  = 4,
   parameter logic [7:0] SYNC    = SYNC_DEFAULT,
   parameter int         TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int DEPTH = 2 ** ADDR_W;
   state_t            r_state, w_next;
   logic              r_run, r_hold, r_done, r_err;
   logic [1:0]        r_k;
   logic [ADDR_W:0]   r_n, r_cnt, r_loaded;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_word;
   logic [7:0]        r_chk;
   logic [TW-1:0]     r_idle;
   logic              w_acc, w_sync, w_bad_n, w_in_frame, w_tmo, w_last;
   // r_run keeps rx_ready low while reset is held and for the first cycle after it
   assign rx_ready     = r_run && r_state != S_WRITE;
   assign w_acc        = rx_valid && rx_ready;
   assign w_sync       = w_acc && r_state == S_IDLE && rx_data == SYNC;
   assign w_bad_n      = rx_data == 8'd0 || int'(rx_data) > DEPTH;
   assign w_in_frame   = r_state == S_COUNT || r_state == S_DATA || r_state == S_CHECK;
   assign w_tmo        = w_in_frame && !w_acc && r_idle == TW'(TIMEOUT - 1);
   assign w_last       = r_cnt + 1'b1 == r_n;
   assign imem_we      = r_state == S_WRITE;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_word;
   assign core_hold    = r_hold || w_sync;
   assign done         = r_done;
   assign err          = r_err;
   assign words_loaded = r_loaded;
   always_comb begin
      w_next = r_state;
      if (w_tmo)
         w_next = S_IDLE;
      else
         case (r_state)
            S_IDLE:  w_next = w_sync ? S_COUNT : S_IDLE;
            S_COUNT: w_next = !w_acc ? S_COUNT : (w_bad_n ? S_IDLE : S_DATA);
            S_DATA:  w_next = (w_acc && r_k == 2'd3) ? S_WRITE : S_DATA;
            S_WRITE: w_next = w_last ? S_CHECK : S_DATA;
            S_CHECK: w_next = w_acc ? S_IDLE : S_CHECK;
            default: w_next = S_IDLE;
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run    <= 1'b0;
         r_hold   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_k      <= '0;
         r_n      <= '0;
         r_cnt    <= '0;
         r_loaded <= '0;
         r_addr   <= '0;
         r_word   <= '0;
         r_chk    <= '0;
         r_idle   <= '0;
      end else begin
         r_run  <= 1'b1;
         r_done <= 1'b0;
         if (!w_in_frame || w_acc)
            r_idle <= '0;
         else
            r_idle <= r_idle + 1'b1;
         if (w_tmo)
            r_err <= 1'b1;
         if (w_sync) begin
            r_err  <= 1'b0;
            r_chk  <= '0;
            r_hold <= 1'b1;
         end
         if (r_state == S_COUNT && w_acc) begin
            if (w_bad_n)
               r_err <= 1'b1;
            else begin
               r_n    <= (ADDR_W + 1)'(rx_data);
               r_k    <= '0;
               r_cnt  <= '0;
               r_addr <= '0;
            end
         end
         if (r_state == S_DATA && w_acc) begin
            r_word[{r_k, 3'b000} +: 8] <= rx_data;
            r_chk                      <= r_chk ^ rx_data;
            r_k                        <= r_k + 2'd1;
         end
         // the address wraps to 0 after a full-depth frame; nothing reads it until the next frame
         if (r_state == S_WRITE) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
         end
         if (r_state == S_CHECK && w_acc) begin
            if (rx_data == r_chk) begin
               r_done   <= 1'b1;
               r_loaded <= r_n;
               r_hold   <= 1'b0;
            end else
               r_err <= 1'b1;
         end
      end
   end
endmodule
